// File: rtl/ntt_pkg.sv
// Shared constants and elaboration-time helpers for the Kyber NTT butterfly datapath.
package ntt_pkg;

    localparam int DEF_DATA_WIDTH = 12;
    localparam int DEF_MODULUS    = 3329;

    localparam logic MODE_CT = 1'b0;
    localparam logic MODE_GS = 1'b1;

    function automatic int barrett_k(input int dw);
        return 2 * dw;
    endfunction

    function automatic longint barrett_m(input int dw, input int q);
        return (longint'(1) << barrett_k(dw)) / longint'(q);
    endfunction

    function automatic int latency(input int mul_lat);
        return mul_lat + 2;
    endfunction

endpackage

// File: rtl/ntt_butterfly_dual_mod_mul.sv
// Pipelined Barrett modular multiplier: product, quotient estimate, single correction,
// then optional extra delay stages so the total depth equals MUL_LAT (MUL_LAT >= 3).
module mod_mul_barrett
    import ntt_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MODULUS    = DEF_MODULUS,
    parameter int MUL_LAT    = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_en,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    output logic [DATA_WIDTH-1:0] o_p
);

    localparam int PW = 2 * DATA_WIDTH;
    localparam int K  = barrett_k(DATA_WIDTH);
    localparam int MW = K + 1;
    localparam int XW = PW + MW;
    localparam logic [MW-1:0] BM  = MW'(barrett_m(DATA_WIDTH, MODULUS));
    localparam logic [PW-1:0] Q_P = PW'(MODULUS);

    logic [PW-1:0]         r_prod;
    logic [PW-1:0]         r_prod2;
    logic [PW-1:0]         r_quot;
    logic [DATA_WIDTH-1:0] r_res [MUL_LAT-2];
    logic [PW-1:0]         w_r;

    // The quotient estimate is at most one short, so the remainder is below 2q
    assign w_r = r_prod2 - r_quot * Q_P;
    assign o_p = r_res[MUL_LAT-3];

    // Multiplier pipeline registers, frozen when the datapath is stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prod  <= '0;
            r_prod2 <= '0;
            r_quot  <= '0;
            for (int i = 0; i < MUL_LAT - 2; i++) begin
                r_res[i] <= '0;
            end
        end else if (i_en) begin
            r_prod   <= PW'(i_a) * PW'(i_b);
            r_prod2  <= r_prod;
            r_quot   <= PW'((XW'(r_prod) * XW'(BM)) >> K);
            r_res[0] <= DATA_WIDTH'((w_r >= Q_P) ? (w_r - Q_P) : w_r);
            for (int i = 1; i < MUL_LAT - 2; i++) begin
                r_res[i] <= r_res[i-1];
            end
        end
    end

endmodule

// File: rtl/ntt_butterfly_dual.sv
// Dual-mode (CT forward / GS inverse) modular butterfly with fixed latency MUL_LAT+2,
// per-sample mode select, optional GS halving and an aligned sideband tag.
module ntt_butterfly_dual
    import ntt_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MODULUS    = DEF_MODULUS,
    parameter int MUL_LAT    = 3,
    parameter int TAG_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  valid_in,
    input  logic                  mode,
    input  logic                  half_en,
    input  logic [TAG_WIDTH-1:0]  tag_in,
    input  logic [DATA_WIDTH-1:0] a_in,
    input  logic [DATA_WIDTH-1:0] b_in,
    input  logic [DATA_WIDTH-1:0] twiddle,
    output logic [DATA_WIDTH-1:0] a_out,
    output logic [DATA_WIDTH-1:0] b_out,
    output logic [TAG_WIDTH-1:0]  tag_out,
    output logic                  valid_out
);

    localparam int DW = DATA_WIDTH;
    localparam logic [DW:0] Q_E = (DW + 1)'(MODULUS);

    function automatic logic [DW-1:0] mod_add(input logic [DW-1:0] x, input logic [DW-1:0] y);
        logic [DW:0] s;
        s = {1'b0, x} + {1'b0, y};
        return DW'((s >= Q_E) ? (s - Q_E) : s);
    endfunction

    function automatic logic [DW-1:0] mod_sub(input logic [DW-1:0] x, input logic [DW-1:0] y);
        logic [DW:0] d;
        d = {1'b0, x} - {1'b0, y};
        return DW'(d[DW] ? (d + Q_E) : d);
    endfunction

    function automatic logic [DW-1:0] mod_half(input logic [DW-1:0] x);
        return DW'((x[0] ? ({1'b0, x} + Q_E) : {1'b0, x}) >> 1);
    endfunction

    logic [DW-1:0]        r_a0, r_b0, r_w0;
    logic                 r_v0, r_mode0, r_half0;
    logic [TAG_WIDTH-1:0] r_tag0;

    logic                 r_v_d    [MUL_LAT+1];
    logic                 r_mode_d [MUL_LAT+1];
    logic                 r_half_d [MUL_LAT+1];
    logic [TAG_WIDTH-1:0] r_tag_d  [MUL_LAT+1];

    logic [DW-1:0] r_ct_a [MUL_LAT];
    logic [DW-1:0] r_ct_sum, r_ct_diff;
    logic [DW-1:0] r_gs_sum [MUL_LAT+1];
    logic [DW-1:0] r_gs_diff, r_gs_w;

    logic [DW-1:0] w_ct_bw, w_gs_prod, w_a_nxt, w_b_nxt;

    // CT multiplies straight from the input register; GS multiplies the registered difference
    mod_mul_barrett #(.DATA_WIDTH(DW), .MODULUS(MODULUS), .MUL_LAT(MUL_LAT)) u_mul_ct (
        .clk(clk), .rst_n(rst_n), .i_en(enable), .i_a(r_b0), .i_b(r_w0), .o_p(w_ct_bw)
    );

    mod_mul_barrett #(.DATA_WIDTH(DW), .MODULUS(MODULUS), .MUL_LAT(MUL_LAT)) u_mul_gs (
        .clk(clk), .rst_n(rst_n), .i_en(enable), .i_a(r_gs_diff), .i_b(r_gs_w), .o_p(w_gs_prod)
    );

    // Result select at the last stage: CT add/sub results or GS sum/product, optionally halved
    always_comb begin
        w_a_nxt = r_ct_sum;
        w_b_nxt = r_ct_diff;
        if (r_mode_d[MUL_LAT] == MODE_GS) begin
            if (r_half_d[MUL_LAT]) begin
                w_a_nxt = mod_half(r_gs_sum[MUL_LAT]);
                w_b_nxt = mod_half(w_gs_prod);
            end else begin
                w_a_nxt = r_gs_sum[MUL_LAT];
                w_b_nxt = w_gs_prod;
            end
        end else begin
            w_a_nxt = r_ct_sum;
            w_b_nxt = r_ct_diff;
        end
    end

    // Input, alignment, add/sub and output registers; all hold while enable is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a0      <= '0;
            r_b0      <= '0;
            r_w0      <= '0;
            r_v0      <= 1'b0;
            r_mode0   <= 1'b0;
            r_half0   <= 1'b0;
            r_tag0    <= '0;
            r_ct_sum  <= '0;
            r_ct_diff <= '0;
            r_gs_diff <= '0;
            r_gs_w    <= '0;
            a_out     <= '0;
            b_out     <= '0;
            tag_out   <= '0;
            valid_out <= 1'b0;
            for (int i = 0; i <= MUL_LAT; i++) begin
                r_v_d[i]    <= 1'b0;
                r_mode_d[i] <= 1'b0;
                r_half_d[i] <= 1'b0;
                r_tag_d[i]  <= '0;
                r_gs_sum[i] <= '0;
            end
            for (int i = 0; i < MUL_LAT; i++) begin
                r_ct_a[i] <= '0;
            end
        end else if (enable) begin
            r_a0    <= a_in;
            r_b0    <= b_in;
            r_w0    <= twiddle;
            r_v0    <= valid_in;
            r_mode0 <= mode;
            r_half0 <= half_en;
            r_tag0  <= tag_in;

            r_v_d[0]    <= r_v0;
            r_mode_d[0] <= r_mode0;
            r_half_d[0] <= r_half0;
            r_tag_d[0]  <= r_tag0;
            r_gs_sum[0] <= mod_add(r_a0, r_b0);
            for (int i = 1; i <= MUL_LAT; i++) begin
                r_v_d[i]    <= r_v_d[i-1];
                r_mode_d[i] <= r_mode_d[i-1];
                r_half_d[i] <= r_half_d[i-1];
                r_tag_d[i]  <= r_tag_d[i-1];
                r_gs_sum[i] <= r_gs_sum[i-1];
            end

            r_ct_a[0] <= r_a0;
            for (int i = 1; i < MUL_LAT; i++) begin
                r_ct_a[i] <= r_ct_a[i-1];
            end
            r_ct_sum  <= mod_add(r_ct_a[MUL_LAT-1], w_ct_bw);
            r_ct_diff <= mod_sub(r_ct_a[MUL_LAT-1], w_ct_bw);

            r_gs_diff <= mod_sub(r_a0, r_b0);
            r_gs_w    <= r_w0;

            a_out     <= w_a_nxt;
            b_out     <= w_b_nxt;
            tag_out   <= r_tag_d[MUL_LAT];
            valid_out <= r_v_d[MUL_LAT];
        end
    end

endmodule

// File: tb/tb_ntt_butterfly_dual.sv
// Randomized and directed bench for ntt_butterfly_dual against an arithmetic reference model.
module tb_ntt_butterfly_dual;

    localparam int DW  = 12;
    localparam int Q   = 3329;
    localparam int TW  = 4;
    localparam int LAT = ntt_pkg::latency(3);

    logic          clk = 1'b0;
    logic          rst_n, enable, valid_in, mode, half_en;
    logic [TW-1:0] tag_in, tag_out;
    logic [DW-1:0] a_in, b_in, twiddle, a_out, b_out;
    logic          valid_out;

    int checks = 0;
    int errors = 0;
    int e = 0;
    int exp_a[int];
    int exp_b[int];
    int exp_t[int];

    ntt_butterfly_dual dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .valid_in(valid_in), .mode(mode),
        .half_en(half_en), .tag_in(tag_in), .a_in(a_in), .b_in(b_in), .twiddle(twiddle),
        .a_out(a_out), .b_out(b_out), .tag_out(tag_out), .valid_out(valid_out)
    );

    always #5 clk = ~clk;

    function automatic int halve(input int x);
        return (x % 2 == 0) ? x / 2 : (x + Q) / 2;
    endfunction

    function automatic void ref_bfly(input bit md, input bit hf, input int a, input int b,
                                     input int w, output int ra, output int rb);
        int bw;
        if (!md) begin
            bw = (b * w) % Q;
            ra = (a + bw) % Q;
            rb = (a - bw + Q) % Q;
        end else begin
            ra = (a + b) % Q;
            rb = (((a - b + Q) % Q) * w) % Q;
            if (hf) begin
                ra = halve(ra);
                rb = halve(rb);
            end
        end
    endfunction

    // One clock: apply inputs, count the enabled edge, record the expected result of a captured sample
    task automatic drive(input bit en, input bit v, input bit md, input bit hf,
                         input int tg, input int a, input int b, input int w);
        int ra, rb;
        enable = en; valid_in = v; mode = md; half_en = hf;
        tag_in = TW'(tg); a_in = DW'(a); b_in = DW'(b); twiddle = DW'(w);
        @(posedge clk);
        if (en) begin
            e++;
            if (v) begin
                ref_bfly(md, hf, a, b, w, ra, rb);
                exp_a[e] = ra;
                exp_b[e] = rb;
                exp_t[e] = tg;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
        checks++;
        if (valid_out !== 1'b0 || a_out !== '0 || b_out !== '0 || tag_out !== '0) begin
            errors++;
            $display("FAIL reset: got v=%0b a=%0d b=%0d t=%0d, want all 0", valid_out, a_out, b_out, tag_out);
        end
        #3 rst_n = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
    endtask

    task automatic test_directed();
        int va[5] = '{100, 3328, 0, 100, 100};
        int vb[5] = '{200, 3328, 100, 200, 200};
        int vw[5] = '{1, 3328, 5, 17, 17};
        bit vm[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        bit vh[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        int ea[5] = '{300, 0, 500, 300, 150};
        int eb[5] = '{3229, 3327, 2829, 1629, 2479};
        for (int n = 0; n < 5; n++) begin
            drive(1'b1, 1'b1, vm[n], vh[n], n + 3, va[n], vb[n], vw[n]);
            for (int j = 1; j <= LAT; j++) begin
                drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
                checks++;
                if (j < LAT && valid_out !== 1'b0) begin
                    errors++;
                    $display("FAIL directed_latency: vec %0d edge %0d got valid_out=%0b want 0", n, j, valid_out);
                end else if (j == LAT && (valid_out !== 1'b1 || a_out !== DW'(ea[n]) ||
                             b_out !== DW'(eb[n]) || tag_out !== TW'(n + 3))) begin
                    errors++;
                    $display("FAIL directed_value: vec %0d got v=%0b a=%0d b=%0d t=%0d want v=1 a=%0d b=%0d t=%0d",
                             n, valid_out, a_out, b_out, tag_out, ea[n], eb[n], n + 3);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int j = 0; j < 13; j++) begin
            if (j < 6) begin
                drive(1'b1, 1'b1, bit'(j % 2), bit'($urandom_range(1, 0)), j,
                      $urandom_range(Q - 1, 0), $urandom_range(Q - 1, 0), $urandom_range(Q - 1, 0));
            end else begin
                drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
            end
            checks++;
            if (exp_a.exists(e - LAT)) begin
                if (valid_out !== 1'b1 || a_out !== DW'(exp_a[e - LAT]) || b_out !== DW'(exp_b[e - LAT]) ||
                    tag_out !== TW'(exp_t[e - LAT])) begin
                    errors++;
                    $display("FAIL back_to_back: cyc %0d got v=%0b a=%0d b=%0d t=%0d want v=1 a=%0d b=%0d t=%0d",
                             j, valid_out, a_out, b_out, tag_out, exp_a[e - LAT], exp_b[e - LAT], exp_t[e - LAT]);
                end
            end else if (valid_out !== 1'b0) begin
                errors++;
                $display("FAIL back_to_back: cyc %0d got valid_out=%0b want 0", j, valid_out);
            end
        end
    endtask

    task automatic test_stall();
        bit en_pat[16] = '{1, 1, 1, 0, 0, 0, 1, 1, 1, 0, 0, 1, 1, 1, 1, 1};
        for (int j = 0; j < 16; j++) begin
            drive(en_pat[j], (j < 3) || !en_pat[j], bit'($urandom_range(1, 0)), bit'($urandom_range(1, 0)),
                  $urandom_range(15, 0), $urandom_range(Q - 1, 0), $urandom_range(Q - 1, 0),
                  $urandom_range(Q - 1, 0));
            checks++;
            if (exp_a.exists(e - LAT)) begin
                if (valid_out !== 1'b1 || a_out !== DW'(exp_a[e - LAT]) || b_out !== DW'(exp_b[e - LAT]) ||
                    tag_out !== TW'(exp_t[e - LAT])) begin
                    errors++;
                    $display("FAIL stall: cyc %0d got v=%0b a=%0d b=%0d t=%0d want v=1 a=%0d b=%0d t=%0d",
                             j, valid_out, a_out, b_out, tag_out, exp_a[e - LAT], exp_b[e - LAT], exp_t[e - LAT]);
                end
            end else if (valid_out !== 1'b0) begin
                errors++;
                $display("FAIL stall: cyc %0d got valid_out=%0b want 0", j, valid_out);
            end
        end
    endtask

    task automatic test_random();
        for (int j = 0; j < 200; j++) begin
            drive(($urandom_range(9, 0) != 0), ($urandom_range(3, 0) != 0), bit'($urandom_range(1, 0)),
                  bit'($urandom_range(1, 0)), $urandom_range(15, 0), $urandom_range(Q - 1, 0),
                  $urandom_range(Q - 1, 0), $urandom_range(Q - 1, 0));
            checks++;
            if (exp_a.exists(e - LAT)) begin
                if (valid_out !== 1'b1 || a_out !== DW'(exp_a[e - LAT]) || b_out !== DW'(exp_b[e - LAT]) ||
                    tag_out !== TW'(exp_t[e - LAT])) begin
                    errors++;
                    $display("FAIL random: cyc %0d got v=%0b a=%0d b=%0d t=%0d want v=1 a=%0d b=%0d t=%0d",
                             j, valid_out, a_out, b_out, tag_out, exp_a[e - LAT], exp_b[e - LAT], exp_t[e - LAT]);
                end
            end else if (valid_out !== 1'b0) begin
                errors++;
                $display("FAIL random: cyc %0d got valid_out=%0b want 0", j, valid_out);
            end
        end
        for (int j = 0; j < LAT + 1; j++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
        end
    endtask

    task automatic test_reset_inflight();
        for (int j = 0; j < 4; j++) begin
            drive(1'b1, 1'b1, bit'(j % 2), 1'b0, j + 8, $urandom_range(Q - 1, 1),
                  $urandom_range(Q - 1, 0), $urandom_range(Q - 1, 1));
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (valid_out !== 1'b0 || a_out !== '0 || b_out !== '0 || tag_out !== '0) begin
            errors++;
            $display("FAIL reset_inflight: got v=%0b a=%0d b=%0d t=%0d, want all 0", valid_out, a_out, b_out, tag_out);
        end
        exp_a.delete();
        exp_b.delete();
        exp_t.delete();
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        for (int j = 0; j < 10; j++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
            checks++;
            if (valid_out !== 1'b0) begin
                errors++;
                $display("FAIL reset_inflight: cyc %0d after release got valid_out=%0b want 0", j, valid_out);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; valid_in = 1'b0; mode = 1'b0; half_en = 1'b0;
        tag_in = '0; a_in = '0; b_in = '0; twiddle = '0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_stall();
        test_random();
        test_reset_inflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
